case_2_prod_accum: RTL and testbench

- Streaming accumulator directly downstream of the case_2 signed multiplier.
- Consumes the 16-bit signed products one per handshake and sums each frame of FRAME_LEN products.
- Emits the frame sum on a valid/ready output with an overflow flag, for the case_2 write-back stage.

---
 rtl/case_2_prod_accum.sv | 118 +++++++++++
 tb/tb_case_2_prod_accum.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/case_2_prod_accum.sv
// Frame accumulator for the case_2 multiplier products: sums FRAME_LEN signed beats per frame.
// Optional macro CASE_2_PROD_ACCUM_SAT_EN clamps out_data on overflow (default build wraps).
module case_2_prod_accum #(
  parameter int unsigned DIN_W     = 16,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned OUT_W     = 17
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [7:0]       frame_idx
);

  localparam int unsigned ACC_W = DIN_W + $clog2(FRAME_LEN);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  din_ext;
  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W-OUT_W:0]     sum_top;
  logic                     sum_ovf;
  logic [OUT_W-1:0]         sum_res;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_ovf_q;
  logic [7:0]               frame_idx_q;
  logic                     accept;
  logic                     last_beat;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (accept && last_beat) state_d = StHold;
      StHold:  if (out_ready)           state_d = StAccum;
      default:                          state_d = StAccum;
    endcase
  end

  // Handshake outputs decode the registered state only
  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StHold);
  end

  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt_q == CNT_W'(FRAME_LEN - 1));

  // First beat of a frame loads rather than adds, so no clear cycle is needed
  always_comb begin
    din_ext  = {{(ACC_W - DIN_W){in_data[DIN_W-1]}}, in_data};
    acc_base = (cnt_q == '0) ? '0 : acc_q;
    sum      = acc_base + din_ext;
  end

  // Overflow iff the bits above the OUT_W sign bit are not a pure sign extension
  always_comb begin
    sum_top = sum[ACC_W-1:OUT_W-1];
    sum_ovf = !((&sum_top) || !(|sum_top));
`ifdef CASE_2_PROD_ACCUM_SAT_EN
    if (sum_ovf) begin
      sum_res = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      sum_res = sum[OUT_W-1:0];
    end
`else
    sum_res = sum[OUT_W-1:0];
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      frame_idx_q <= '0;
    end else begin
      if (accept) begin
        acc_q <= sum;
        if (last_beat) begin
          cnt_q      <= '0;
          out_data_q <= sum_res;
          out_ovf_q  <= sum_ovf;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if ((state_q == StHold) && out_ready) begin
        frame_idx_q <= frame_idx_q + 8'd1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_case_2_prod_accum.sv
// Directed bench for case_2_prod_accum: table of frames plus hold, gap and reset sequences.
module tb_case_2_prod_accum;

  localparam int unsigned DIN_W     = 16;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned OUT_W     = 17;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DIN_W-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic [7:0]       frame_idx;

  int errors = 0;
  int checks = 0;
  int exp_idx = 0;

  typedef struct {
    logic [3:0][15:0] d;
    int               exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[$];

  case_2_prod_accum #(
    .DIN_W    (DIN_W),
    .FRAME_LEN(FRAME_LEN),
    .OUT_W    (OUT_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .frame_idx(frame_idx)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int a, input int b, input int c, input int e,
                         input int exp_wrap, input int exp_sat, input logic ovf);
    vec_t v;
    v.d[0] = a[15:0];
    v.d[1] = b[15:0];
    v.d[2] = c[15:0];
    v.d[3] = e[15:0];
`ifdef CASE_2_PROD_ACCUM_SAT_EN
    v.exp_data = exp_sat;
`else
    v.exp_data = exp_wrap;
`endif
    v.exp_ovf = ovf;
    vecs.push_back(v);
  endtask

  // Sends four beats back to back; each beat must be accepted on its edge
  task automatic send4(input int a, input int b, input int c, input int e);
    int d[4];
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d[i][15:0];
      chk("in_ready_beat", {31'd0, in_ready}, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  int acc_cnt;
  int seen;
  int gap_d[4];
  logic [OUT_W-1:0] held;

  initial begin
    // 32767*4 = 0x1FFFC -> -4 in 17 bits; -32768*4 = 0x20000 -> 0 in 17 bits
    add_vec(100, -50, 7, 3, 60, 60, 1'b0);
    add_vec(32767, 32767, 32767, 32767, -4, 65535, 1'b1);
    add_vec(-32768, -32768, -32768, -32768, 0, -65536, 1'b1);
    add_vec(-1, -1, -1, -1, -4, -4, 1'b0);
    add_vec(32767, 32767, 1, 0, 65535, 65535, 1'b0);
    add_vec(32767, 32767, 1, 1, -65536, 65535, 1'b1);
    add_vec(-32768, -32768, 0, 0, -65536, -65536, 1'b0);
    add_vec(-32768, -32768, 0, -1, 65535, -65536, 1'b1);
    add_vec(16384, 16384, 16384, 16384, -65536, 65535, 1'b1);

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 0);
    chk("rst_frame_idx", {24'd0, frame_idx}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);

    // Table frames, out_ready held high so the handshake follows immediately
    out_ready = 1'b1;
    foreach (vecs[v]) begin
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        in_data  = vecs[v].d[i];
        step();
        chk("no_early_valid", {31'd0, out_valid}, 0);
      end
      in_data = vecs[v].d[3];
      step();
      in_valid = 1'b0;
      chk("tbl_out_valid", {31'd0, out_valid}, 1);
      chk("tbl_in_ready", {31'd0, in_ready}, 0);
      chk("tbl_out_data", $signed(out_data), vecs[v].exp_data);
      chk("tbl_out_ovf", {31'd0, out_ovf}, {31'd0, vecs[v].exp_ovf});
      chk("tbl_idx_before", {24'd0, frame_idx}, exp_idx);
      step();
      exp_idx = (exp_idx + 1) % 256;
      chk("tbl_out_valid_low", {31'd0, out_valid}, 0);
      chk("tbl_idx_after", {24'd0, frame_idx}, exp_idx);
    end

    // Back-pressure: result held for 10 cycles while the next beat waits
    out_ready = 1'b0;
    send4(10, 20, 30, 40);
    in_valid = 1'b1;
    in_data  = 16'd7;
    for (int i = 0; i < 10; i++) begin
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      chk("hold_out_data", $signed(out_data), 100);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_idx   = (exp_idx + 1) % 256;
    chk("hs_out_valid", {31'd0, out_valid}, 0);
    chk("hs_in_ready", {31'd0, in_ready}, 1);
    chk("hs_idx", {24'd0, frame_idx}, exp_idx);
    step();
    in_data = 16'd8;
    step();
    in_data = 16'd9;
    step();
    in_data = 16'd10;
    step();
    in_valid = 1'b0;
    chk("after_hold_valid", {31'd0, out_valid}, 1);
    chk("after_hold_data", $signed(out_data), 34);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_idx   = (exp_idx + 1) % 256;

    // Random in_valid gaps over {1,2,3,4}
    gap_d[0] = 1; gap_d[1] = 2; gap_d[2] = 3; gap_d[3] = 4;
    acc_cnt = 0;
    seen    = 0;
    for (int t = 0; t < 200 && !out_valid; t++) begin
      in_valid = ($urandom_range(0, 2) == 0) && (acc_cnt < 4);
      in_data  = gap_d[acc_cnt % 4][15:0];
      if (in_valid && in_ready) acc_cnt++;
      step();
    end
    in_valid = 1'b0;
    seen = out_valid ? 1 : 0;
    chk("gap_done", seen, 1);
    chk("gap_accepts", acc_cnt, 4);
    chk("gap_out_data", $signed(out_data), 10);
    held = out_data;
    step();
    chk("gap_stable", $signed(out_data), $signed(held));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset after two beats discards the partial frame
    in_valid = 1'b1;
    in_data  = 16'd100;
    step();
    in_data = 16'd200;
    step();
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_idx", {24'd0, frame_idx}, 0);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();
    send4(5, 5, 5, 5);
    chk("rst_frame_valid", {31'd0, out_valid}, 1);
    chk("rst_frame_data", $signed(out_data), 20);
    chk("rst_frame_ovf", {31'd0, out_ovf}, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rst_frame_idx", {24'd0, frame_idx}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
